// File: rtl/spike_dispatcher_if.sv
// Spike dispatcher bus: router-side spike input, MAC-side source output and timestep status.
// The dispatcher uses the slave modport; the environment driving it uses master.
interface spike_dispatcher_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] spike_in_addr;
  logic              spike_in_valid;
  logic              spike_in_ready;
  logic              timestep_end;
  logic [ADDR_W-1:0] source_address;
  logic              src_valid;
  logic              src_ready;
  logic              clear;
  logic              step_done;
  logic              step_overrun;
  logic [15:0]       step_spike_count;

  modport master (
    output spike_in_addr, spike_in_valid, timestep_end, src_ready,
    input  spike_in_ready, source_address, src_valid, clear, step_done,
           step_overrun, step_spike_count
  );

  modport slave (
    input  spike_in_addr, spike_in_valid, timestep_end, src_ready,
    output spike_in_ready, source_address, src_valid, clear, step_done,
           step_overrun, step_spike_count
  );
endinterface

// File: rtl/spike_dispatcher.sv
// Spike FIFO feeding the MAC array, with timestep drain/clear sequencing.
// Define SPIKE_STATS_EN to report per-timestep dispatched spike counts.
module spike_dispatcher #(
  parameter int                ADDR_W       = 12,
  parameter int                FIFO_DEPTH   = 8,
  parameter logic [ADDR_W-1:0] INVALID_ADDR = '1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spike_dispatcher_if.slave bus_io
);
  // state | meaning
  // RUN   | accepting spikes and dispatching them
  // DRAIN | timestep ended; no intake, flushing FIFO and output register
  // CLEAR | one-cycle accumulator clear / step_done
  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state_q;
  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] src_addr_q;
  logic              src_valid_q;
  logic              clear_q;
  logic              overrun_q;

  logic full, empty, in_ready, push, advance, pop;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = (state_q == RUN) && !full;
  assign push     = bus_io.spike_in_valid && in_ready;
  assign advance  = !src_valid_q || bus_io.src_ready;
  assign pop      = advance && !empty && (state_q != CLEAR);

  assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus_io.spike_in_addr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      src_addr_q  <= INVALID_ADDR;
      src_valid_q <= 1'b0;
      clear_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (advance && state_q != CLEAR) begin
        if (pop) begin
          src_addr_q  <= mem_q[rd_ptr_q];
          src_valid_q <= 1'b1;
        end else begin
          src_addr_q  <= INVALID_ADDR;
          src_valid_q <= 1'b0;
        end
      end
      if (bus_io.timestep_end && state_q != RUN) overrun_q <= 1'b1;
      clear_q <= 1'b0;
      case (state_q)
        RUN:   if (bus_io.timestep_end) state_q <= DRAIN;
        // Waiting for an idle output register leaves a gap after the last handshake.
        DRAIN: if (empty && !src_valid_q) begin
          state_q <= CLEAR;
          clear_q <= 1'b1;
        end
        CLEAR:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus_io.spike_in_ready = in_ready;
  assign bus_io.source_address = src_addr_q;
  assign bus_io.src_valid      = src_valid_q;
  assign bus_io.clear          = clear_q;
  assign bus_io.step_done      = clear_q;
  assign bus_io.step_overrun   = overrun_q;

`ifdef SPIKE_STATS_EN
  logic [15:0] stat_q;
  logic [15:0] step_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q       <= '0;
      step_count_q <= '0;
    end else if (state_q == CLEAR) begin
      step_count_q <= stat_q;
      stat_q       <= '0;
    end else if (src_valid_q && bus_io.src_ready && stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign bus_io.step_spike_count = step_count_q;
`else
  assign bus_io.step_spike_count = 16'd0;
`endif
endmodule

// File: tb/tb_spike_dispatcher.sv
// Self-checking bench for spike_dispatcher: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_spike_dispatcher;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  spike_dispatcher_if #(.ADDR_W(12)) dif ();

  spike_dispatcher #(.ADDR_W(12), .FIFO_DEPTH(DEPTH), .INVALID_ADDR(12'hFFF)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of pending spikes, an output slot, and timestep phase flags.
  logic [11:0] m_q[$];
  logic        m_out_valid = 1'b0;
  logic [11:0] m_out_addr  = 12'hFFF;
  bit          m_drain = 0, m_clear = 0, m_over = 0;
  int          m_stat = 0, m_step = 0;
  bit          acc, hs, q_empty, out_idle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_out_valid = 1'b0;
      m_out_addr  = 12'hFFF;
      m_drain = 0; m_clear = 0; m_over = 0;
      m_stat = 0; m_step = 0;
    end else begin
      q_empty  = (m_q.size() == 0);
      out_idle = !m_out_valid;
      acc = dif.spike_in_valid && !m_drain && !m_clear && (m_q.size() < DEPTH);
      hs  = m_out_valid && dif.src_ready;
      if (hs && m_stat < 65535) m_stat++;
      if (m_clear) begin
        m_step = m_stat;
        m_stat = 0;
      end else if (out_idle || dif.src_ready) begin
        if (!q_empty) begin
          m_out_addr  = m_q.pop_front();
          m_out_valid = 1'b1;
        end else begin
          m_out_addr  = 12'hFFF;
          m_out_valid = 1'b0;
        end
      end
      if (acc) m_q.push_back(dif.spike_in_addr);
      if (dif.timestep_end && (m_drain || m_clear)) m_over = 1;
      if (m_clear) m_clear = 0;
      else if (m_drain) begin
        if (q_empty && out_idle) begin
          m_drain = 0;
          m_clear = 1;
        end
      end else if (dif.timestep_end) m_drain = 1;
    end
  end

  function automatic logic [15:0] exp_count(input int n);
`ifdef SPIKE_STATS_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("m_src_valid", dif.src_valid, m_out_valid);
    chk("m_source_address", dif.source_address, m_out_addr);
    chk("m_clear", dif.clear, m_clear);
    chk("m_step_done", dif.step_done, m_clear);
    chk("m_step_overrun", dif.step_overrun, m_over);
    chk("m_spike_in_ready", dif.spike_in_ready, !m_drain && !m_clear && (m_q.size() < DEPTH));
    chk("m_step_spike_count", dif.step_spike_count, exp_count(m_step));
  end

  initial begin
    int clears;
    rst = 1'b1;
    dif.spike_in_addr  = '0;
    dif.spike_in_valid = 1'b0;
    dif.timestep_end   = 1'b0;
    dif.src_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_src_valid", dif.src_valid, 0);
    chk("rst_addr", dif.source_address, 12'hFFF);
    chk("rst_clear", dif.clear, 0);
    chk("rst_step_done", dif.step_done, 0);
    chk("rst_overrun", dif.step_overrun, 0);
    chk("rst_ready", dif.spike_in_ready, 1);
    chk("rst_count", dif.step_spike_count, 0);

    // 1: three spikes back to back, then timestep end
    dif.src_ready = 1'b1;
    dif.spike_in_valid = 1'b1; dif.spike_in_addr = 12'd3; tick;
    chk("t1_latency", dif.src_valid, 0);
    dif.spike_in_addr = 12'd4; tick;
    chk("t1_addr3", dif.source_address, 12'd3);
    dif.spike_in_addr = 12'd5; tick;
    chk("t1_addr4", dif.source_address, 12'd4);
    dif.spike_in_valid = 1'b0; dif.timestep_end = 1'b1; tick;
    chk("t1_addr5", dif.source_address, 12'd5);
    dif.timestep_end = 1'b0; tick;
    chk("t1_idle_valid", dif.src_valid, 0);
    chk("t1_idle_clear", dif.clear, 0);
    tick;
    chk("t1_clear", dif.clear, 1);
    chk("t1_step_done", dif.step_done, 1);
    tick;
    chk("t1_clear_off", dif.clear, 0);
    chk("t1_count", dif.step_spike_count, exp_count(3));

    // 2: fill while stalled, then drain in order
    dif.src_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      dif.spike_in_valid = 1'b1; dif.spike_in_addr = 12'(i); tick;
    end
    chk("t2_full_ready", dif.spike_in_ready, 0);
    dif.spike_in_addr = 12'd10; tick;
    chk("t2_full_hold", dif.spike_in_ready, 0);
    dif.spike_in_valid = 1'b0;
    dif.src_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      chk("t2_order", dif.source_address, 12'(i));
      tick;
    end
    chk("t2_empty", dif.src_valid, 0);
    dif.timestep_end = 1'b1; tick;
    dif.timestep_end = 1'b0;
    repeat (3) tick;
    chk("t2_count", dif.step_spike_count, exp_count(9));

    // 3: stalling MAC during dispatch of 10, 11
    dif.src_ready = 1'b0;
    dif.spike_in_valid = 1'b1; dif.spike_in_addr = 12'd10; tick;
    dif.spike_in_addr = 12'd11; tick;
    dif.spike_in_valid = 1'b0; dif.timestep_end = 1'b1; tick;
    chk("t3_hold10", dif.source_address, 12'd10);
    dif.timestep_end = 1'b0; dif.src_ready = 1'b1; tick;
    chk("t3_addr11", dif.source_address, 12'd11);
    dif.src_ready = 1'b0; tick;
    chk("t3_hold11a", dif.source_address, 12'd11);
    chk("t3_noclear_a", dif.clear, 0);
    tick;
    chk("t3_hold11b", dif.source_address, 12'd11);
    chk("t3_noclear_b", dif.clear, 0);
    dif.src_ready = 1'b1; tick;
    chk("t3_idle", dif.src_valid, 0);
    chk("t3_noclear_c", dif.clear, 0);
    dif.src_ready = 1'b0; tick;
    chk("t3_clear", dif.clear, 1);
    tick;
    chk("t3_count", dif.step_spike_count, exp_count(2));

    // 4: empty timestep
    dif.timestep_end = 1'b1; tick;
    dif.timestep_end = 1'b0;
    chk("t4_clear_early", dif.clear, 0);
    tick;
    chk("t4_clear", dif.clear, 1);
    tick;
    chk("t4_count", dif.step_spike_count, exp_count(0));

    // 5: second timestep_end while draining
    dif.spike_in_valid = 1'b1; dif.spike_in_addr = 12'd7; tick;
    dif.spike_in_valid = 1'b0; dif.timestep_end = 1'b1; tick;
    tick;
    dif.timestep_end = 1'b0;
    chk("t5_overrun", dif.step_overrun, 1);
    dif.src_ready = 1'b1;
    clears = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (dif.clear) clears++;
    end
    chk("t5_one_clear", clears, 1);
    chk("t5_sticky", dif.step_overrun, 1);

    // 6: reset during DRAIN with spikes queued
    dif.src_ready = 1'b0;
    for (int i = 21; i <= 25; i++) begin
      dif.spike_in_valid = 1'b1; dif.spike_in_addr = 12'(i); tick;
    end
    dif.spike_in_valid = 1'b0; dif.timestep_end = 1'b1; tick;
    dif.timestep_end = 1'b0; tick;
    rst = 1'b1;
    #1;
    chk("t6_valid", dif.src_valid, 0);
    chk("t6_addr", dif.source_address, 12'hFFF);
    chk("t6_clear", dif.clear, 0);
    chk("t6_overrun", dif.step_overrun, 0);
    #1 rst = 1'b0;
    dif.src_ready = 1'b1;
    tick;
    chk("t6_ready", dif.spike_in_ready, 1);
    chk("t6_empty_a", dif.src_valid, 0);
    tick;
    chk("t6_empty_b", dif.src_valid, 0);
    chk("t6_no_clear", dif.clear, 0);

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
